// File: rtl/pong_state_rx.sv
// pong_state_rx
//
// Node-side receiver for the game-state stream sent by the game server. It reassembles
// 8-byte packets (SYNC, BX_HI, BX_LO, BY_HI, BY_LO, OY_HI, OY_LO, CK) from a byte
// stream and verifies each one. It then updates ball and opponent-paddle coordinates
// atomically and tracks link health.
//
// Ports:
//   clock      system clock
//   reset_n    asynchronous active-low reset
//   rx_data    byte from the serial receiver
//   rx_valid   one-cycle strobe qualifying rx_data
//   ball_x     latched ball x (11 bits)
//   ball_y     latched ball y (11 bits)
//   opp_y      latched opponent paddle top y (11 bits)
//   pkt_valid  one-cycle pulse, coordinates updated
//   cksum_err  one-cycle pulse, checksum mismatch
//   frame_err  one-cycle pulse, malformed HI byte or inter-byte timeout
//   range_err  one-cycle pulse, coordinate out of range (range-check build only, else 0)
//   link_up    a good packet arrived within the last LINK_TIMEOUT cycles
//
// Build option: define PONG_RX_RANGE_CHECK_EN to reject checksum-good packets whose
// coordinates fall outside the playfield.

module pong_state_rx #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned BYTE_TIMEOUT = 1024,
  parameter int unsigned LINK_TIMEOUT = 2_500_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic [10:0] opp_y,
  output logic        pkt_valid,
  output logic        cksum_err,
  output logic        frame_err,
  output logic        range_err,
  output logic        link_up
);

  localparam int unsigned ByteCntW = $clog2(BYTE_TIMEOUT + 1);
  localparam int unsigned LinkCntW = $clog2(LINK_TIMEOUT + 1);
  localparam logic [ByteCntW-1:0] ByteLimit = ByteCntW'(BYTE_TIMEOUT);
  localparam logic [LinkCntW-1:0] LinkLimit = LinkCntW'(LINK_TIMEOUT);

  localparam logic [10:0] RstBallX = 11'd500;
  localparam logic [10:0] RstBallY = 11'd500;
  localparam logic [10:0] RstOppY  = 11'd448;

  typedef enum logic [1:0] {
    StHunt,
    StPayload,
    StCheck
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          xor_q, xor_d;
  logic [10:0]         sh_bx_q, sh_bx_d;
  logic [10:0]         sh_by_q, sh_by_d;
  logic [10:0]         sh_oy_q, sh_oy_d;
  logic [ByteCntW-1:0] byte_cnt_q, byte_cnt_d, byte_cnt_inc;
  logic [LinkCntW-1:0] link_cnt_q, link_cnt_d, link_cnt_inc;
  logic [10:0]         ball_x_q, ball_x_d;
  logic [10:0]         ball_y_q, ball_y_d;
  logic [10:0]         opp_y_q, opp_y_d;
  logic                pkt_valid_q, pkt_valid_d;
  logic                cksum_err_q, cksum_err_d;
  logic                frame_err_q, frame_err_d;
  logic                link_up_q, link_up_d;
  logic                accept;
  logic                hi_bad;

`ifdef PONG_RX_RANGE_CHECK_EN
  logic range_err_q, range_err_d;
  logic range_ok;

  assign range_ok = (sh_bx_q >= 11'd160) && (sh_bx_q <= 11'd1120) &&
                    (sh_by_q >= 11'd128) && (sh_by_q <= 11'd896) &&
                    (sh_oy_q >= 11'd128) && (sh_oy_q <= 11'd896);
`endif

  assign byte_cnt_inc = byte_cnt_q + ByteCntW'(1);
  assign link_cnt_inc = link_cnt_q + LinkCntW'(1);
  // Even indices (0, 2, 4) are HI bytes; only their low three bits may be set.
  assign hi_bad = ~idx_q[0] && (rx_data[7:3] != 5'd0);

  // Packet FSM, shadow registers and inter-byte timeout.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    xor_d       = xor_q;
    sh_bx_d     = sh_bx_q;
    sh_by_d     = sh_by_q;
    sh_oy_d     = sh_oy_q;
    byte_cnt_d  = byte_cnt_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    opp_y_d     = opp_y_q;
    pkt_valid_d = 1'b0;
    cksum_err_d = 1'b0;
    frame_err_d = 1'b0;
    accept      = 1'b0;
`ifdef PONG_RX_RANGE_CHECK_EN
    range_err_d = 1'b0;
`endif

    unique case (state_q)
      StHunt: begin
        byte_cnt_d = '0;
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = StPayload;
          idx_d   = 3'd0;
          xor_d   = 8'd0;
        end
      end

      StPayload, StCheck: begin
        if (!rx_valid) begin
          if (byte_cnt_inc == ByteLimit) begin
            frame_err_d = 1'b1;
            state_d     = StHunt;
            byte_cnt_d  = '0;
          end else begin
            byte_cnt_d = byte_cnt_inc;
          end
        end else begin
          // A byte on the would-be timeout cycle is processed and cancels the timeout.
          byte_cnt_d = '0;
          if (state_q == StPayload) begin
            if (hi_bad) begin
              frame_err_d = 1'b1;
              state_d     = StHunt;
            end else begin
              xor_d = xor_q ^ rx_data;
              case (idx_q)
                3'd0:    sh_bx_d[10:8] = rx_data[2:0];
                3'd1:    sh_bx_d[7:0]  = rx_data;
                3'd2:    sh_by_d[10:8] = rx_data[2:0];
                3'd3:    sh_by_d[7:0]  = rx_data;
                3'd4:    sh_oy_d[10:8] = rx_data[2:0];
                default: sh_oy_d[7:0]  = rx_data;
              endcase
              if (idx_q == 3'd5) begin
                state_d = StCheck;
              end else begin
                idx_d = idx_q + 3'd1;
              end
            end
          end else begin
            state_d = StHunt;
            if (rx_data == xor_q) begin
`ifdef PONG_RX_RANGE_CHECK_EN
              if (range_ok) begin
                accept = 1'b1;
              end else begin
                range_err_d = 1'b1;
              end
`else
              accept = 1'b1;
`endif
            end else begin
              cksum_err_d = 1'b1;
            end
          end
        end
      end

      default: state_d = StHunt;
    endcase

    // All three coordinates load on the same edge so a partial packet is never visible.
    if (accept) begin
      ball_x_d    = sh_bx_q;
      ball_y_d    = sh_by_q;
      opp_y_d     = sh_oy_q;
      pkt_valid_d = 1'b1;
    end
  end

  // Link monitor: cleared by each accepted packet, otherwise saturates at LINK_TIMEOUT.
  always_comb begin
    link_cnt_d = link_cnt_q;
    link_up_d  = link_up_q;
    if (accept) begin
      link_cnt_d = '0;
      link_up_d  = 1'b1;
    end else if (link_cnt_q != LinkLimit) begin
      link_cnt_d = link_cnt_inc;
      if (link_cnt_inc == LinkLimit) begin
        link_up_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StHunt;
      idx_q       <= 3'd0;
      xor_q       <= 8'd0;
      sh_bx_q     <= 11'd0;
      sh_by_q     <= 11'd0;
      sh_oy_q     <= 11'd0;
      byte_cnt_q  <= '0;
      link_cnt_q  <= '0;
      ball_x_q    <= RstBallX;
      ball_y_q    <= RstBallY;
      opp_y_q     <= RstOppY;
      pkt_valid_q <= 1'b0;
      cksum_err_q <= 1'b0;
      frame_err_q <= 1'b0;
      link_up_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      xor_q       <= xor_d;
      sh_bx_q     <= sh_bx_d;
      sh_by_q     <= sh_by_d;
      sh_oy_q     <= sh_oy_d;
      byte_cnt_q  <= byte_cnt_d;
      link_cnt_q  <= link_cnt_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      opp_y_q     <= opp_y_d;
      pkt_valid_q <= pkt_valid_d;
      cksum_err_q <= cksum_err_d;
      frame_err_q <= frame_err_d;
      link_up_q   <= link_up_d;
    end
  end

`ifdef PONG_RX_RANGE_CHECK_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      range_err_q <= 1'b0;
    end else begin
      range_err_q <= range_err_d;
    end
  end

  assign range_err = range_err_q;
`else
  assign range_err = 1'b0;
`endif

  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign opp_y     = opp_y_q;
  assign pkt_valid = pkt_valid_q;
  assign cksum_err = cksum_err_q;
  assign frame_err = frame_err_q;
  assign link_up   = link_up_q;

endmodule

// File: tb/tb_pong_state_rx.sv
// Testbench for pong_state_rx. Directed packet sequence. Every expected packet outcome is
// pushed to a scoreboard queue when the packet is driven. A monitor pops and compares the
// queue whenever the DUT pulses an outcome.

module tb_pong_state_rx;

  localparam int unsigned BT = 32;
  localparam int unsigned LT = 3000;

  localparam int EvGood  = 0;
  localparam int EvCksum = 1;
  localparam int EvFrame = 2;
  localparam int EvRange = 3;

  logic        clock;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [10:0] ball_x;
  logic [10:0] ball_y;
  logic [10:0] opp_y;
  logic        pkt_valid;
  logic        cksum_err;
  logic        frame_err;
  logic        range_err;
  logic        link_up;

  pong_state_rx #(
    .SYNC_BYTE   (8'hA5),
    .BYTE_TIMEOUT(BT),
    .LINK_TIMEOUT(LT)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .ball_x   (ball_x),
    .ball_y   (ball_y),
    .opp_y    (opp_y),
    .pkt_valid(pkt_valid),
    .cksum_err(cksum_err),
    .frame_err(frame_err),
    .range_err(range_err),
    .link_up  (link_up)
  );

  typedef struct {
    int          kind;
    logic [10:0] bx;
    logic [10:0] by;
    logic [10:0] oy;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [10:0] m_bx = 11'd500;
  logic [10:0] m_by = 11'd500;
  logic [10:0] m_oy = 11'd448;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input logic [10:0] bx, input logic [10:0] by,
                      input logic [10:0] oy);
    exp_t e;
    if (kind == EvGood) begin
      m_bx = bx;
      m_by = by;
      m_oy = oy;
    end
    e.kind = kind;
    e.bx   = m_bx;
    e.by   = m_by;
    e.oy   = m_oy;
    sb.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Sends a full packet; ck_flip corrupts the checksum, gap_len idle cycles follow byte gap_idx.
  task automatic send_pkt(input logic [10:0] bx, input logic [10:0] by, input logic [10:0] oy,
                          input logic [7:0] ck_flip, input int kind, input int gap_idx,
                          input int gap_len);
    logic [7:0] b[8];
    b[0] = 8'hA5;
    b[1] = {5'd0, bx[10:8]};
    b[2] = bx[7:0];
    b[3] = {5'd0, by[10:8]};
    b[4] = by[7:0];
    b[5] = {5'd0, oy[10:8]};
    b[6] = oy[7:0];
    b[7] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6] ^ ck_flip;
    push(kind, bx, by, oy);
    for (int i = 0; i < 8; i++) begin
      send_byte(b[i]);
      if (i == gap_idx) idle(gap_len);
    end
  endtask

  // Scoreboard monitor, sampling on the inactive edge.
  always @(negedge clock) begin
    int   np;
    int   kind;
    exp_t e;
    if (reset_n) begin
      np = int'(pkt_valid) + int'(cksum_err) + int'(frame_err) + int'(range_err);
      if (np != 0) begin
        check("one_pulse", np, 1);
        check("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e    = sb.pop_front();
          kind = pkt_valid ? EvGood : cksum_err ? EvCksum : frame_err ? EvFrame : EvRange;
          check("ev_kind", kind, e.kind);
          check("ev_ball_x", ball_x, e.bx);
          check("ev_ball_y", ball_y, e.by);
          check("ev_opp_y", opp_y, e.oy);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, %0d expectations left", sb.size());
    $fatal(1, "watchdog");
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_ball_x"}, ball_x, 500);
    check({tag, "_ball_y"}, ball_y, 500);
    check({tag, "_opp_y"}, opp_y, 448);
    check({tag, "_pulses"}, {pkt_valid, cksum_err, frame_err, range_err}, 0);
    check({tag, "_link_up"}, link_up, 0);
  endtask

  initial begin
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #12;
    check_reset_vals("rst");
    #10 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Bad checksum before any good packet: outputs and link stay at reset values.
    send_pkt(11'd500, 11'd300, 11'd448, 8'h01, EvCksum, -1, 0);
    check("ck_bad_pulse", cksum_err, 1);
    idle(1);
    check("ck_bad_pulse_len", cksum_err, 0);
    check("ck_bad_ball_y", ball_y, 500);
    check("ck_bad_link", link_up, 0);

    // Good packet A5 01 F4 01 2C 01 C0 19.
    send_pkt(11'd500, 11'd300, 11'd448, 8'h00, EvGood, -1, 0);
    check("good_pv", pkt_valid, 1);
    check("good_ball_y", ball_y, 300);
    idle(1);
    check("good_pv_len", pkt_valid, 0);
    check("good_link", link_up, 1);

    // Garbage in HUNT is ignored; 0xA5 inside the payload is data.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    send_pkt(11'h2A5, 11'd200, 11'd400, 8'h00, EvGood, -1, 0);
    check("sync_data_ball_x", ball_x, 677);

    // Malformed HI byte, then a normal packet.
    push(EvFrame, 0, 0, 0);
    send_byte(8'hA5);
    send_byte(8'h08);
    check("hi_bad_frame", frame_err, 1);
    send_pkt(11'd800, 11'd600, 11'd256, 8'h00, EvGood, -1, 0);
    check("after_frame_ball_x", ball_x, 800);

    // Inter-byte timeout after three payload bytes.
    push(EvFrame, 0, 0, 0);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h90);
    send_byte(8'h01);
    idle(BT - 1);
    check("to_early", frame_err, 0);
    idle(1);
    check("to_fire", frame_err, 1);
    send_pkt(11'd400, 11'd336, 11'd320, 8'h00, EvGood, -1, 0);
    check("after_to_opp_y", opp_y, 320);

    // Byte landing on the timeout cycle is processed, no error.
    send_pkt(11'd420, 11'd340, 11'd330, 8'h00, EvGood, 3, BT - 1);
    check("to_edge_ball_x", ball_x, 420);

    // Out-of-range ball x: rejected only in the range-check build.
`ifdef PONG_RX_RANGE_CHECK_EN
    send_pkt(11'd100, 11'd300, 11'd300, 8'h00, EvRange, -1, 0);
    check("range_err", range_err, 1);
    check("range_hold_x", ball_x, 420);
`else
    send_pkt(11'd100, 11'd300, 11'd300, 8'h00, EvGood, -1, 0);
    check("range_off_err", range_err, 0);
    check("range_off_x", ball_x, 100);
`endif

    // Reset mid-packet discards the partial packet.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'hF4);
    reset_n = 1'b0;
    #2;
    check_reset_vals("midrst");
    m_bx = 11'd500;
    m_by = 11'd500;
    m_oy = 11'd448;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    send_byte(8'h01);
    send_byte(8'h2C);
    send_byte(8'h01);
    check("midrst_ignored_x", ball_x, 500);
    send_pkt(11'd700, 11'd700, 11'd700, 8'h00, EvGood, -1, 0);

    // Link timeout: link_up falls exactly LT cycles after the last good packet.
    idle(LT - 1);
    check("link_before_to", link_up, 1);
    idle(1);
    check("link_after_to", link_up, 0);
    check("link_hold_x", ball_x, 700);
    check("link_hold_oy", opp_y, 700);
    send_pkt(11'd640, 11'd480, 11'd240, 8'h00, EvGood, -1, 0);
    idle(1);
    check("link_restored", link_up, 1);

    for (int i = 0; i < 10 && sb.size() != 0; i++) idle(1);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
